det_calc_param: RTL

Parametrised determinant calculator, the successor to the fixed 2x2, 8-bit determinant unit. It accepts a 2x2 or 3x3 matrix of signed DATA_W-bit elements through a valid/ready stream, row-major. It computes the determinant sequentially on a single shared multiplier and presents a sign-extended result with a one-cycle done pulse. It sits under the lab top level in place of the 2x2 unit and is driven by the same start/done controller style.

---
 rtl/det_pkg.sv | 23 ++
 rtl/det_calc_controller.sv | 107 ++++++++++
 rtl/det_calc_param.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/det_pkg.sv
// Shared types and sizing helpers for the parametrised determinant calculator.
package det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DONE
    } state_t;

    typedef enum logic {
        MODE_2X2,
        MODE_3X3
    } mode_t;

    localparam int STEPS_2X2 = 2;
    localparam int STEPS_3X3 = 9;

    function automatic int out_w(input int data_w);
        return 3 * data_w + 3;
    endfunction

endpackage

// File: rtl/det_calc_controller.sv
// Sequencing for the determinant calculator: element intake, compute steps, done pulse.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; mode captured with start
//   LOAD    | accepting N*N elements, row-major, on in_valid && in_ready
//   COMPUTE | one multiply per cycle, step 0..STEPS-1
//   DONE    | result published, done high for this single cycle
module det_calc_controller
    import det_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_mode,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_accept,
    output logic [3:0] o_elem_idx,
    output logic       o_clear,
    output logic       o_compute,
    output logic [3:0] o_step,
    output logic       o_last,
    output mode_t      o_mode
);

    state_t     r_state;
    mode_t      r_mode;
    logic [3:0] r_cnt;
    logic [3:0] r_step;
    logic       r_in_ready;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_last_elem;
    logic [3:0] w_last_step;
    logic       w_accept;

    assign w_last_elem = (r_mode == MODE_3X3) ? 4'd8 : 4'd3;
    assign w_last_step = (r_mode == MODE_3X3) ? 4'(STEPS_3X3 - 1) : 4'(STEPS_2X2 - 1);
    assign w_accept    = i_in_valid && r_in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mode     <= MODE_2X2;
            r_cnt      <= '0;
            r_step     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= LOAD;
                        r_mode     <= mode_t'(i_mode);
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (r_cnt == w_last_elem) begin
                            r_state    <= COMPUTE;
                            r_cnt      <= '0;
                            r_step     <= '0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                COMPUTE: begin
                    if (r_step == w_last_step) begin
                        r_state <= DONE;
                        r_step  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_accept   = w_accept;
    assign o_elem_idx = r_cnt;
    assign o_clear    = w_accept && (r_cnt == w_last_elem);
    assign o_compute  = (r_state == COMPUTE);
    assign o_step     = r_step;
    assign o_last     = (r_state == COMPUTE) && (r_step == w_last_step);
    assign o_mode     = r_mode;

endmodule

// File: rtl/det_calc_param.sv
// 2x2 / 3x3 signed determinant on one shared multiplier; datapath here, sequencing in
// det_calc_controller.
module det_calc_param
    import det_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int OUT_W  = out_w(DATA_W)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     in_ready,
    output logic                     busy,
    output logic signed [OUT_W-1:0]  out_put,
    output logic                     done
);

    localparam int MW = 2 * DATA_W + 1;

    logic              w_accept;
    logic [3:0]        w_elem_idx;
    logic              w_clear;
    logic              w_compute;
    logic [3:0]        w_step;
    logic              w_last;
    mode_t             w_mode;

    logic signed [DATA_W-1:0] r_elem [9];
    logic signed [MW-1:0]     r_tmp;
    logic signed [OUT_W-1:0]  r_acc;
    logic signed [OUT_W-1:0]  r_out;

    logic signed [MW-1:0]     w_op_a;
    logic signed [MW-1:0]     w_op_b;
    logic signed [2*MW-1:0]   w_prod;
    logic signed [OUT_W-1:0]  w_prod_o;
    logic signed [MW-1:0]     w_prod_t;
    logic signed [OUT_W-1:0]  w_acc_next;
    logic signed [MW-1:0]     w_tmp_next;
    logic                     w_tmp_ld;
    logic                     w_tmp_sub;
    logic                     w_acc_ld;
    logic                     w_acc_sub;

    det_calc_controller u_ctrl (
        .clock      (clock),
        .reset      (reset),
        .i_start    (start),
        .i_mode     (mode),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .o_busy     (busy),
        .o_done     (done),
        .o_accept   (w_accept),
        .o_elem_idx (w_elem_idx),
        .o_clear    (w_clear),
        .o_compute  (w_compute),
        .o_step     (w_step),
        .o_last     (w_last),
        .o_mode     (w_mode)
    );

    function automatic logic signed [MW-1:0] sx(input logic signed [DATA_W-1:0] v);
        return {{(MW - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // 3x3 schedule: per minor k, tmp = p1, tmp -= p2, acc +/-= coef_k * tmp.
    always_comb begin
        w_op_a    = '0;
        w_op_b    = '0;
        w_tmp_ld  = 1'b0;
        w_tmp_sub = 1'b0;
        w_acc_ld  = 1'b0;
        w_acc_sub = 1'b0;
        if (w_mode == MODE_2X2) begin
            case (w_step)
                4'd0: begin w_op_a = sx(r_elem[0]); w_op_b = sx(r_elem[3]); w_acc_ld = 1'b1; end
                4'd1: begin w_op_a = sx(r_elem[1]); w_op_b = sx(r_elem[2]);
                            w_acc_ld = 1'b1; w_acc_sub = 1'b1; end
                default: ;
            endcase
        end else begin
            case (w_step)
                4'd0: begin w_op_a = sx(r_elem[4]); w_op_b = sx(r_elem[8]); w_tmp_ld = 1'b1; end
                4'd1: begin w_op_a = sx(r_elem[5]); w_op_b = sx(r_elem[7]);
                            w_tmp_ld = 1'b1; w_tmp_sub = 1'b1; end
                4'd2: begin w_op_a = sx(r_elem[0]); w_op_b = r_tmp; w_acc_ld = 1'b1; end
                4'd3: begin w_op_a = sx(r_elem[3]); w_op_b = sx(r_elem[8]); w_tmp_ld = 1'b1; end
                4'd4: begin w_op_a = sx(r_elem[5]); w_op_b = sx(r_elem[6]);
                            w_tmp_ld = 1'b1; w_tmp_sub = 1'b1; end
                4'd5: begin w_op_a = sx(r_elem[1]); w_op_b = r_tmp;
                            w_acc_ld = 1'b1; w_acc_sub = 1'b1; end
                4'd6: begin w_op_a = sx(r_elem[3]); w_op_b = sx(r_elem[7]); w_tmp_ld = 1'b1; end
                4'd7: begin w_op_a = sx(r_elem[4]); w_op_b = sx(r_elem[6]);
                            w_tmp_ld = 1'b1; w_tmp_sub = 1'b1; end
                4'd8: begin w_op_a = sx(r_elem[2]); w_op_b = r_tmp; w_acc_ld = 1'b1; end
                default: ;
            endcase
        end
    end

    assign w_prod     = w_op_a * w_op_b;
    assign w_prod_o   = w_prod[OUT_W-1:0];
    assign w_prod_t   = w_prod[MW-1:0];
    assign w_acc_next = w_acc_sub ? (r_acc - w_prod_o) : (r_acc + w_prod_o);
    assign w_tmp_next = w_tmp_sub ? (r_tmp - w_prod_t) : w_prod_t;

    // The final step writes the result straight into out_put so it lands on DONE entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                r_elem[k] <= '0;
            end
            r_tmp <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (w_accept && (w_elem_idx < 4'd9)) begin
                r_elem[w_elem_idx] <= data_in;
            end
            if (w_clear) begin
                r_acc <= '0;
            end else if (w_compute && w_acc_ld) begin
                r_acc <= w_acc_next;
            end
            if (w_compute && w_tmp_ld) begin
                r_tmp <= w_tmp_next;
            end
            if (w_last) begin
                r_out <= w_acc_next;
            end
        end
    end

    assign out_put = r_out;

endmodule
